// File: rtl/mem_writeback_stage.sv
// -----------------------------------------------------------------------------
// mem_writeback_stage
//
// Final stage of the 3-stage RV32I pipeline. It takes the execute stage's ALU
// result, rs2 data, opcode, funct3 and rd. Loads and stores go to data memory
// through a valid/ready request channel and a valid-only response channel.
// Every instruction that writes a register ends up on the register-file write
// port. While a memory transaction is outstanding, s3_in_ready is held low so
// the upstream pipeline stalls.
//
// Ports:
//   clk              pipeline clock, rising edge
//   reset            asynchronous, active-high reset
//   s3_in_valid      execute stage presents an instruction
//   s3_in_ready      stage can accept (FSM is IDLE)
//   s3_alu_out       ALU result / memory byte address
//   s3_rs2_data      store data
//   s3_opcode        instruction opcode
//   s3_func          funct3
//   s3_rd            destination register
//   dmem_req_valid   memory request valid
//   dmem_req_ready   memory accepts request
//   dmem_addr        word-aligned memory address
//   dmem_we          byte write mask (0 for loads)
//   dmem_din         lane-replicated store data
//   dmem_resp_valid  load data valid (only observed in RESP)
//   dmem_dout        load word
//   wb_we            register-file write enable (one-cycle pulse)
//   wb_addr          register-file write address
//   wb_data          register-file write data
//   s3_trap          misaligned-access pulse
//
// Optional feature macro: MEM_STAGE_MISALIGN_TRAP_EN
//   When defined, misaligned halfword/word accesses are trapped at accept.
//   They issue no request and no write-back, and s3_trap pulses for one cycle.
//   When undefined, s3_trap is tied low. Misaligned accesses then use the
//   word-aligned address and the normal extraction rules.
// -----------------------------------------------------------------------------

`ifndef CPU_DATA_BITS
`define CPU_DATA_BITS 32
`endif
`ifndef CPU_ADDR_BITS
`define CPU_ADDR_BITS 32
`endif

module mem_writeback_stage #(
  parameter int DATA_BITS = `CPU_DATA_BITS,
  parameter int ADDR_BITS = `CPU_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s3_in_valid,
  output logic                 s3_in_ready,
  input  logic [DATA_BITS-1:0] s3_alu_out,
  input  logic [DATA_BITS-1:0] s3_rs2_data,
  input  logic [6:0]           s3_opcode,
  input  logic [2:0]           s3_func,
  input  logic [4:0]           s3_rd,
  output logic                 dmem_req_valid,
  input  logic                 dmem_req_ready,
  output logic [ADDR_BITS-1:0] dmem_addr,
  output logic [3:0]           dmem_we,
  output logic [DATA_BITS-1:0] dmem_din,
  input  logic                 dmem_resp_valid,
  input  logic [DATA_BITS-1:0] dmem_dout,
  output logic                 wb_we,
  output logic [4:0]           wb_addr,
  output logic [DATA_BITS-1:0] wb_data,
  output logic                 s3_trap
);

  // FSM encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // State and captured instruction
  logic [1:0]           state_reg, state_next;
  logic [6:0]           op_reg;
  logic [2:0]           func_reg;
  logic [4:0]           rd_reg;
  logic [ADDR_BITS-1:0] addr_reg;
  logic [DATA_BITS-1:0] data_reg;

  // Write-back registers
  logic                 wb_we_reg, wb_we_next;
  logic [4:0]           wb_addr_reg, wb_addr_next;
  logic [DATA_BITS-1:0] wb_data_reg, wb_data_next;

  // Accept / decode of the incoming instruction
  logic accept;
  logic in_is_load;
  logic in_is_store;
  logic in_is_mem;
  logic in_misaligned;

  assign accept      = s3_in_valid && (state_reg == IDLE);
  assign in_is_load  = (s3_opcode == OPC_LOAD);
  assign in_is_store = (s3_opcode == OPC_STORE);
  assign in_is_mem   = in_is_load || in_is_store;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  // Access-size classification at accept. Loads use 000/100 for bytes and
  // 001/101 for halves. Stores only use 000 and 001. Every other funct3
  // value is a word access.
  logic in_is_byte;
  logic in_is_half;
  logic trap_reg, trap_next;

  always_comb begin
    in_is_byte = (s3_func == 3'b000) || (in_is_load && (s3_func == 3'b100));
    in_is_half = (s3_func == 3'b001) || (in_is_load && (s3_func == 3'b101));
  end

  assign in_misaligned = in_is_mem && !in_is_byte &&
                         (in_is_half ? s3_alu_out[0] : (s3_alu_out[1:0] != 2'b00));
  assign trap_next     = accept && in_misaligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trap_reg <= 1'b0;
    end else begin
      trap_reg <= trap_next;
    end
  end

  assign s3_trap = trap_reg;
`else
  assign in_misaligned = 1'b0;
  assign s3_trap       = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && in_is_mem && !in_misaligned) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (dmem_req_ready) begin
          state_next = (op_reg == OPC_STORE) ? IDLE : RESP;
        end
      end
      RESP: begin
        if (dmem_resp_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Load data extraction from the returned word
  logic [1:0]           ld_off;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [DATA_BITS-1:0] ld_value;

  assign ld_off  = addr_reg[1:0];
  assign ld_byte = dmem_dout[8*ld_off +: 8];
  assign ld_half = dmem_dout[16*ld_off[1] +: 16];

  always_comb begin
    ld_value = dmem_dout;
    case (func_reg)
      3'b000:  ld_value = {{(DATA_BITS-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_value = {{(DATA_BITS-8){1'b0}}, ld_byte};
      3'b001:  ld_value = {{(DATA_BITS-16){ld_half[15]}}, ld_half};
      3'b101:  ld_value = {{(DATA_BITS-16){1'b0}}, ld_half};
      default: ld_value = dmem_dout;
    endcase
  end

  // Write-back: ALU results one cycle after accept; loads one cycle after the
  // response edge. Branches, stores and rd==0 never write. Address and data
  // keep their previous values between pulses.
  always_comb begin
    wb_we_next   = 1'b0;
    wb_addr_next = wb_addr_reg;
    wb_data_next = wb_data_reg;
    if (accept && !in_is_mem && (s3_opcode != OPC_BRANCH) && (s3_rd != 5'd0)) begin
      wb_we_next   = 1'b1;
      wb_addr_next = s3_rd;
      wb_data_next = s3_alu_out;
    end else if ((state_reg == RESP) && dmem_resp_valid && (rd_reg != 5'd0)) begin
      wb_we_next   = 1'b1;
      wb_addr_next = rd_reg;
      wb_data_next = ld_value;
    end
  end

  // Store lane encoding. Each byte lane computes its own enable and data, so
  // the SB/SH replication falls out of the per-lane source selection.
  logic       st_is_byte;
  logic       st_is_half;
  logic [3:0] lane_we;

  assign st_is_byte = (func_reg == 3'b000);
  assign st_is_half = (func_reg == 3'b001);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      always_comb begin
        if (st_is_byte) begin
          lane_we[gi]       = (ld_off == LANE);
          dmem_din[8*gi +: 8] = data_reg[7:0];
        end else if (st_is_half) begin
          lane_we[gi]       = (ld_off[1] == LANE[1]);
          dmem_din[8*gi +: 8] = data_reg[8*(gi % 2) +: 8];
        end else begin
          lane_we[gi]       = 1'b1;
          dmem_din[8*gi +: 8] = data_reg[8*gi +: 8];
        end
      end
    end
  endgenerate

  // Request channel is driven straight from the captured registers, so it
  // stays stable for as long as the memory holds off ready.
  assign dmem_req_valid = (state_reg == REQ);
  assign dmem_addr      = {addr_reg[ADDR_BITS-1:2], 2'b00};
  assign dmem_we        = ((state_reg == REQ) && (op_reg == OPC_STORE)) ? lane_we : 4'b0000;
  assign s3_in_ready    = (state_reg == IDLE);

  // Sequential state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      op_reg      <= 7'd0;
      func_reg    <= 3'd0;
      rd_reg      <= 5'd0;
      addr_reg    <= '0;
      data_reg    <= '0;
      wb_we_reg   <= 1'b0;
      wb_addr_reg <= 5'd0;
      wb_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg   <= s3_opcode;
        func_reg <= s3_func;
        rd_reg   <= s3_rd;
        addr_reg <= s3_alu_out[ADDR_BITS-1:0];
        data_reg <= s3_rs2_data;
      end
      wb_we_reg   <= wb_we_next;
      wb_addr_reg <= wb_addr_next;
      wb_data_reg <= wb_data_next;
    end
  end

  assign wb_we   = wb_we_reg;
  assign wb_addr = wb_addr_reg;
  assign wb_data = wb_data_reg;

endmodule

// File: tb/tb_mem_writeback_stage.sv
module tb_mem_writeback_stage;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  logic        clk = 1'b0;
  logic        reset;
  logic        s3_in_valid;
  logic        s3_in_ready;
  logic [31:0] s3_alu_out;
  logic [31:0] s3_rs2_data;
  logic [6:0]  s3_opcode;
  logic [2:0]  s3_func;
  logic [4:0]  s3_rd;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_din;
  logic        dmem_resp_valid;
  logic [31:0] dmem_dout;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        s3_trap;

  mem_writeback_stage dut (
    .clk             (clk),
    .reset           (reset),
    .s3_in_valid     (s3_in_valid),
    .s3_in_ready     (s3_in_ready),
    .s3_alu_out      (s3_alu_out),
    .s3_rs2_data     (s3_rs2_data),
    .s3_opcode       (s3_opcode),
    .s3_func         (s3_func),
    .s3_rd           (s3_rd),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_addr       (dmem_addr),
    .dmem_we         (dmem_we),
    .dmem_din        (dmem_din),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_dout       (dmem_dout),
    .wb_we           (wb_we),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .s3_trap         (s3_trap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] din;
    logic        chk_din;
  } req_t;

  wb_t  wb_q[$];
  req_t req_q[$];
  int   trap_q[$];
  int   wb_stamps[$];

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops expected responses whenever the DUT presents one.
  wb_t  wb_e;
  req_t req_e;
  always @(negedge clk) begin
    if (wb_we === 1'b1) begin
      wb_stamps.push_back(cycle);
      if (wb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got wb_we=1 addr=%0d data=0x%08h required no write-back",
                 wb_addr, wb_data);
      end else begin
        wb_e = wb_q.pop_front();
        check("wb_addr", {27'd0, wb_addr}, {27'd0, wb_e.rd});
        check("wb_data", wb_data, wb_e.data);
        $display("wb  rd=%0d data=0x%08h", wb_addr, wb_data);
      end
    end
    if (dmem_req_valid === 1'b1 && dmem_req_ready === 1'b1) begin
      if (req_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req_unexpected: got request addr=0x%08h required no request", dmem_addr);
      end else begin
        req_e = req_q.pop_front();
        check("req_addr", dmem_addr, req_e.addr);
        check("req_we", {28'd0, dmem_we}, {28'd0, req_e.we});
        if (req_e.chk_din) check("req_din", dmem_din, req_e.din);
        $display("req addr=0x%08h we=%b din=0x%08h", dmem_addr, dmem_we, dmem_din);
      end
    end
    if (s3_trap === 1'b1) begin
      checks++;
      if (trap_q.size() == 0) begin
        errors++;
        $display("FAIL trap_unexpected: got s3_trap=1 required 0");
      end else begin
        void'(trap_q.pop_front());
        $display("trap");
      end
    end
  end

  task automatic issue(input logic [6:0] op, input logic [2:0] f, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] d);
    s3_in_valid = 1'b1;
    s3_opcode   = op;
    s3_func     = f;
    s3_rd       = rd;
    s3_alu_out  = a;
    s3_rs2_data = d;
    @(posedge clk);
    #1;
    s3_in_valid = 1'b0;
  endtask

  task automatic wait_hs(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (dmem_req_valid === 1'b1 && dmem_req_ready === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: got no handshake in 20 cycles required handshake", name);
    end
  endtask

  task automatic do_load(input string name, input logic [2:0] f, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] dout,
                         input logic [31:0] exp_data, input logic exp_we);
    if (exp_we) wb_q.push_back('{rd: rd, data: exp_data});
    req_q.push_back('{addr: {addr[31:2], 2'b00}, we: 4'b0000, din: 32'h0, chk_din: 1'b0});
    dmem_req_ready = 1'b1;
    issue(OPC_LOAD, f, rd, addr, 32'h5555_5555);
    wait_hs(name);
    @(posedge clk);
    #1;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_dout       = dout;
    @(posedge clk);
    #1;
    dmem_resp_valid = 1'b0;
    dmem_dout       = 32'h0;
    @(negedge clk);
    check({name, "_wb_we"}, {31'd0, wb_we}, {31'd0, exp_we});
    check({name, "_in_ready"}, {31'd0, s3_in_ready}, 32'd1);
  endtask

  task automatic do_store(input string name, input logic [2:0] f, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [3:0] exp_we,
                          input logic [31:0] exp_din);
    req_q.push_back('{addr: {addr[31:2], 2'b00}, we: exp_we, din: exp_din, chk_din: 1'b1});
    dmem_req_ready = 1'b1;
    issue(OPC_STORE, f, 5'd3, addr, rs2);
    wait_hs(name);
    @(posedge clk);
    #1;
    dmem_req_ready = 1'b0;
    @(negedge clk);
    check({name, "_in_ready"}, {31'd0, s3_in_ready}, 32'd1);
    check({name, "_wb_we"}, {31'd0, wb_we}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    s3_in_valid     = 1'b0;
    s3_alu_out      = 32'h0;
    s3_rs2_data     = 32'h0;
    s3_opcode       = 7'h0;
    s3_func         = 3'h0;
    s3_rd           = 5'h0;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_dout       = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, s3_in_ready}, 32'd1);
    check("rst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
    check("rst_dmem_we", {28'd0, dmem_we}, 32'd0);
    check("rst_wb_we", {31'd0, wb_we}, 32'd0);
    check("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_trap", {31'd0, s3_trap}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single ALU op
    wb_q.push_back('{rd: 5'd5, data: 32'h0000_1234});
    issue(OPC_OP, 3'b000, 5'd5, 32'h0000_1234, 32'h0);
    @(negedge clk);
    check("add_wb_we", {31'd0, wb_we}, 32'd1);

    // Three back-to-back ALU ops -> consecutive pulses
    @(posedge clk);
    #1;
    wb_stamps.delete();
    wb_q.push_back('{rd: 5'd1, data: 32'h1111_0001});
    wb_q.push_back('{rd: 5'd2, data: 32'h2222_0002});
    wb_q.push_back('{rd: 5'd31, data: 32'hFFFF_FFFF});
    issue(OPC_OP, 3'b000, 5'd1, 32'h1111_0001, 32'h0);
    issue(OPC_OPIMM, 3'b000, 5'd2, 32'h2222_0002, 32'h0);
    issue(OPC_OPIMM, 3'b110, 5'd31, 32'hFFFF_FFFF, 32'h0);
    @(negedge clk);
    #1;
    check("b2b_count", wb_stamps.size(), 32'd3);
    if (wb_stamps.size() == 3) check("b2b_span", wb_stamps[2] - wb_stamps[0], 32'd2);

    // ALU op to x0 and a branch: no write-back (monitor flags any pulse)
    issue(OPC_OPIMM, 3'b000, 5'd0, 32'hDEAD_0000, 32'h0);
    issue(OPC_BRANCH, 3'b000, 5'd7, 32'h0000_0040, 32'h0);
    @(negedge clk);
    check("nowb_wb_we", {31'd0, wb_we}, 32'd0);

    // SB with memory stalling two cycles
    @(posedge clk);
    #1;
    req_q.push_back('{addr: 32'h100, we: 4'b1000, din: 32'hDDDD_DDDD, chk_din: 1'b1});
    dmem_req_ready = 1'b0;
    issue(OPC_STORE, 3'b000, 5'd4, 32'h0000_0103, 32'hAABB_CCDD);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) dmem_req_ready = 1'b1;
      @(negedge clk);
      check("sb_req_valid", {31'd0, dmem_req_valid}, 32'd1);
      check("sb_addr", dmem_addr, 32'h0000_0100);
      check("sb_we", {28'd0, dmem_we}, 32'h8);
      check("sb_din", dmem_din, 32'hDDDD_DDDD);
      check("sb_in_ready", {31'd0, s3_in_ready}, 32'd0);
      check("sb_wb_we", {31'd0, wb_we}, 32'd0);
      @(posedge clk);
      #1;
    end
    dmem_req_ready = 1'b0;
    @(negedge clk);
    check("sb_done_in_ready", {31'd0, s3_in_ready}, 32'd1);
    check("sb_done_req_valid", {31'd0, dmem_req_valid}, 32'd0);
    @(posedge clk);
    #1;

    // More stores
    do_store("sh", 3'b001, 32'h0000_0102, 32'h1111_BEEF, 4'b1100, 32'hBEEF_BEEF);
    do_store("sw", 3'b010, 32'h0000_0200, 32'hCAFE_BABE, 4'b1111, 32'hCAFE_BABE);

    // Loads with extraction
    do_load("lb",  3'b000, 5'd10, 32'h0000_0102, 32'h0080_0000, 32'hFFFF_FF80, 1'b1);
    do_load("lbu", 3'b100, 5'd11, 32'h0000_0102, 32'h0080_0000, 32'h0000_0080, 1'b1);
    do_load("lh",  3'b001, 5'd12, 32'h0000_0102, 32'h8001_0000, 32'hFFFF_8001, 1'b1);
    do_load("lhu", 3'b101, 5'd13, 32'h0000_0100, 32'h1234_F00D, 32'h0000_F00D, 1'b1);
    do_load("lb1", 3'b000, 5'd14, 32'h0000_0101, 32'h1234_5678, 32'h0000_0056, 1'b1);
    do_load("lw",  3'b010, 5'd15, 32'h0000_0100, 32'h1234_5678, 32'h1234_5678, 1'b1);
    do_load("lw_x0", 3'b010, 5'd0, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0, 1'b0);

    // Misaligned word load
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    @(posedge clk);
    #1;
    trap_q.push_back(1);
    dmem_req_ready = 1'b1;
    issue(OPC_LOAD, 3'b010, 5'd16, 32'h0000_0102, 32'h0);
    @(negedge clk);
    check("mis_trap", {31'd0, s3_trap}, 32'd1);
    check("mis_req_valid", {31'd0, dmem_req_valid}, 32'd0);
    check("mis_in_ready", {31'd0, s3_in_ready}, 32'd1);
    @(negedge clk);
    check("mis_trap_clear", {31'd0, s3_trap}, 32'd0);
    check("mis_wb_we", {31'd0, wb_we}, 32'd0);
    dmem_req_ready = 1'b0;
`else
    do_load("mis_lw", 3'b010, 5'd16, 32'h0000_0102, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    check("mis_trap", {31'd0, s3_trap}, 32'd0);
`endif

    // Reset while waiting for a load response
    @(posedge clk);
    #1;
    req_q.push_back('{addr: 32'h300, we: 4'b0000, din: 32'h0, chk_din: 1'b0});
    dmem_req_ready = 1'b1;
    issue(OPC_LOAD, 3'b010, 5'd9, 32'h0000_0300, 32'h0);
    wait_hs("rstresp");
    @(posedge clk);
    #1;
    dmem_req_ready = 1'b0;
    check("pre_rst_in_ready", {31'd0, s3_in_ready}, 32'd0);
    reset = 1'b1;
    #1;
    check("arst_in_ready", {31'd0, s3_in_ready}, 32'd1);
    check("arst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
    @(negedge clk);
    check("arst_wb_addr", {27'd0, wb_addr}, 32'd0);
    check("arst_wb_data", wb_data, 32'd0);
    @(posedge clk);
    #1;
    reset           = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_dout       = 32'h1234_5678;
    @(posedge clk);
    #1;
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    check("post_rst_wb_we", {31'd0, wb_we}, 32'd0);
    check("post_rst_in_ready", {31'd0, s3_in_ready}, 32'd1);
    check("post_rst_req_valid", {31'd0, dmem_req_valid}, 32'd0);

    repeat (3) @(negedge clk);
    check("wb_q_drained", wb_q.size(), 32'd0);
    check("req_q_drained", req_q.size(), 32'd0);
    check("trap_q_drained", trap_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_writeback_stage.md
Name: mem_writeback_stage

Overview:
Stage #3 of the 3-stage RV32I pipeline. It sits directly downstream of the execute stage and consumes that stage's ALU result, rs2 data, opcode, funct3 and rd. It performs the data-memory load/store transaction through a valid/ready request channel and a valid response channel, then drives the register-file write port. It stalls the upstream pipeline while a memory transaction is outstanding.

Parameters:
DATA_BITS, `CPU_DATA_BITS (32), datapath width; only 32 is supported.
ADDR_BITS, `CPU_ADDR_BITS (32), data-memory byte-address width.

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
s3_in_valid  in  1  execute stage presents an instruction
s3_in_ready  out  1  stage can accept; equals (state==IDLE)
s3_alu_out  in  DATA_BITS  ALU result; the memory byte address for loads/stores
s3_rs2_data  in  DATA_BITS  store data
s3_opcode  in  7  instruction opcode
s3_func  in  3  funct3
s3_rd  in  5  destination register
dmem_req_valid  out  1  memory request valid
dmem_req_ready  in  1  memory accepts request
dmem_addr  out  ADDR_BITS  word-aligned address, {addr[ADDR_BITS-1:2],2'b00}
dmem_we  out  4  byte write mask; 0 for loads
dmem_din  out  DATA_BITS  lane-replicated store data
dmem_resp_valid  in  1  load data valid
dmem_dout  in  DATA_BITS  load word
wb_we  out  1  register-file write enable, one-cycle pulse
wb_addr  out  5  register-file write address
wb_data  out  DATA_BITS  register-file write data
s3_trap  out  1  misaligned-access flag (see Optional Feature)

Behaviour:
- Accept when s3_in_valid && s3_in_ready. The instruction is captured into internal registers (op, func, rd, addr, store data) at the rising edge.
- FSM states: IDLE, REQ, RESP.
  - IDLE: on accept of a LOAD (7'b0000011) or STORE (7'b0100011), go to REQ. Otherwise stay in IDLE.
  - REQ: dmem_req_valid=1, with addr/we/din driven from captured registers and held stable until dmem_req_ready. On handshake, a STORE goes to IDLE and a LOAD goes to RESP.
  - RESP: wait for dmem_resp_valid. On that edge, load the write-back registers and go to IDLE.
- Non-memory instructions: write-back one cycle after accept. wb_we=1 with wb_data=s3_alu_out. Back-to-back accepts are allowed, one per cycle.
- No write-back for BRANCH (7'b1100011), STORE, or rd==0.
- Load write-back: wb_we pulses the cycle after the response edge. s3_in_ready is already 1 in that same cycle.
- Load extraction, with off=addr[1:0]:
  - LB 000 / LBU 100: byte at dout[8*off+:8], sign-/zero-extended.
  - LH 001 / LHU 101: half at dout[16*off[1]+:16], sign-/zero-extended.
  - LW 010: full word.
  - Other funct3 values are treated as LW.
- Store encoding:
  - SB: we=4'b0001<<off, din={4{rs2[7:0]}}.
  - SH: we=4'b0011<<{off[1],1'b0}, din={2{rs2[15:0]}}.
  - SW: we=4'b1111, din=rs2.
  - Other funct3 values are treated as SW.
- dmem_resp_valid is ignored outside RESP.
- Reset is asynchronous and overrides everything, mid-transaction included:
  - state=IDLE.
  - dmem_req_valid=0, dmem_we=0.
  - wb_we=0, wb_addr=0, wb_data=0, s3_trap=0.
  - The captured registers are cleared.
  - A response arriving after reset is discarded.
- Memory ops have a minimum latency of 3 cycles (accept, req, resp) plus any memory wait cycles. A store can complete in 2.

Optional Feature:
Macro MEM_STAGE_MISALIGN_TRAP_EN.
- Defined: the alignment check runs at accept.
  - A misaligned access is a halfword with addr[0]=1, or a word with addr[1:0]!=0.
  - A misaligned access issues no memory request, stays in IDLE, performs no write-back, and pulses s3_trap for one cycle after the accept.
- Undefined: s3_trap is tied to 0, and misaligned addresses proceed using the word-aligned dmem_addr with the extraction rules above.

Test Plan:
- Reset, then ADD with rd=5 and alu_out=0x0000_1234 -> next cycle wb_we=1, wb_addr=5, wb_data=0x0000_1234. Issue three ALU ops back-to-back -> three consecutive wb pulses.
- SB with addr=0x103 and rs2=0xAABB_CCDD, dmem_req_ready held low for 2 cycles -> dmem_addr=0x100, we=4'b1000, din=0xDDDD_DDDD, all stable for 3 cycles. wb_we stays 0 and s3_in_ready=0 until the handshake.
- LB addr=0x102 and LBU addr=0x102 with dout=0x0080_0000 -> wb_data=0xFFFF_FF80 and 0x0000_0080 respectively. LH addr=0x102 with dout=0x8001_0000 -> wb_data=0xFFFF_8001.
- LW with rd=0 and a response -> wb_we stays 0. A BRANCH -> wb_we stays 0.
- Assert reset while in RESP, then drive dmem_resp_valid after reset deasserts -> state IDLE, no wb_we pulse, and dmem_req_valid=0 during and after reset.
- With MEM_STAGE_MISALIGN_TRAP_EN defined, LW addr=0x102 -> s3_trap pulses 1 cycle, and there is no dmem_req_valid and no wb_we. Without the macro -> request to 0x100 and normal write-back.
